// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: a 128-bit state is substituted LANES bytes per cycle
// through shared forward S-boxes, then held until the consumer accepts it.
module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Forward S-box, row x0..xf concatenated; entry x lives at bits [8x +: 8].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{x, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, SUB, HOLD} fsmState;

    fsmState        stateReg, stateNext;
    logic [0:127]   bufReg, bufNext, bufSub;
    logic [CW-1:0]  cntReg, cntNext;
    logic           lastChunk;
    logic [4:0]     baseByte;
    logic [7:0]     laneOut [LANES];

    assign lastChunk = (cntReg == CW'(N - 1));
    assign baseByte  = 5'(cntReg) * 5'(LANES);

    // Each lane reads its byte of the current chunk out of the buffer.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [4:0] laneIdx;
            assign laneIdx     = baseByte + 5'(gi);
            assign laneOut[gi] = sbox(bufReg[{laneIdx[3:0], 3'b000} +: 8]);
        end
    endgenerate

    // Byte gi is owned by lane gi%LANES and is rewritten only while its chunk is active.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
            localparam int CHUNK = gi / LANES;
            localparam int LANE  = gi % LANES;
            assign bufSub[8*gi +: 8] = (cntReg == CW'(CHUNK)) ? laneOut[LANE]
                                                              : bufReg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        stateNext = stateReg;
        bufNext   = bufReg;
        cntNext   = cntReg;
        case (stateReg)
            IDLE: begin
                if (in_valid) begin
                    bufNext   = state_in;
                    cntNext   = '0;
                    stateNext = SUB;
                end
            end
            SUB: begin
                bufNext = bufSub;
                if (lastChunk) begin
                    cntNext   = '0;
                    stateNext = HOLD;
                end else begin
                    cntNext = cntReg + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
            bufReg   <= '0;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            bufReg   <= bufNext;
            cntReg   <= cntNext;
        end
    end

    // Outputs decode the state register only; the buffer is masked until HOLD.
    assign in_ready  = (stateReg == IDLE);
    assign out_valid = (stateReg == HOLD);
    assign state_out = out_valid ? bufReg : '0;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: one instance per legal LANES value,
// FIPS-197 vectors, boundary bytes, backpressure, back-to-back and mid-run reset.
module tb_sub_bytes_iter;

    localparam logic [0:127] B_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [0:127] B_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [0:127] SR_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [0:127] ZEROS  = {16{8'h00}};
    localparam logic [0:127] ONES   = {16{8'hff}};
    localparam logic [0:127] X53    = {16{8'h53}};
    localparam logic [0:127] S63    = {16{8'h63}};
    localparam logic [0:127] S16    = {16{8'h16}};
    localparam logic [0:127] SED    = {16{8'hed}};

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   inValid, inReady, outValid, outReady;
    logic [0:127] stateIn  [5];
    logic [0:127] stateOut [5];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dut
            sub_bytes_iter #(.LANES(1 << gi)) dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (inValid[gi]),
                .in_ready (inReady[gi]),
                .state_in (stateIn[gi]),
                .out_valid(outValid[gi]),
                .out_ready(outReady[gi]),
                .state_out(stateOut[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:127] shiftRows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
        return o;
    endfunction

    // Called one negedge after acceptance; counts negedges until out_valid.
    task automatic waitOut(input int k, output int lat);
        lat = 0;
        while (outValid[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Starts at a negedge with instance k idle; leaves it idle at a negedge.
    task automatic runBlock(input int k, input logic [0:127] din, input logic [0:127] exp,
                            input int nLat, input string tag);
        int lat;
        inValid[k]  = 1'b1;
        stateIn[k]  = din;
        outReady[k] = 1'b1;
        @(negedge clk);
        inValid[k] = 1'b0;
        stateIn[k] = ~din;
        check($sformatf("L%0d %s busy", 1 << k, tag), 128'(inReady[k]), 128'(0));
        waitOut(k, lat);
        $display("L%0d %s: latency %0d, out %h", 1 << k, tag, lat, stateOut[k]);
        check($sformatf("L%0d %s latency", 1 << k, tag), 128'(lat), 128'(nLat));
        check($sformatf("L%0d %s data", 1 << k, tag), stateOut[k], exp);
        @(negedge clk);
        check($sformatf("L%0d %s valid drop", 1 << k, tag), 128'(outValid[k]), 128'(0));
        check($sformatf("L%0d %s ready back", 1 << k, tag), 128'(inReady[k]), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        int accCyc [2];
        int nAcc;
        int nOut;
        bit pend;
        logic [0:127] outs [2];

        rst      = 1'b1;
        inValid  = '0;
        outReady = '0;
        for (int k = 0; k < 5; k++) stateIn[k] = '0;
        #12;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("L%0d reset in_ready", 1 << k), 128'(inReady[k]), 128'(1));
            check($sformatf("L%0d reset out_valid", 1 << k), 128'(outValid[k]), 128'(0));
            check($sformatf("L%0d reset state_out", 1 << k), stateOut[k], ZEROS);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Appendix B and boundary bytes on every lane count.
        for (int k = 0; k < 5; k++) begin
            runBlock(k, B_IN,  B_OUT, 16 >> k, "appB");
            runBlock(k, ZEROS, S63,   16 >> k, "zeros");
            runBlock(k, ONES,  S16,   16 >> k, "ones");
            runBlock(k, X53,   SED,   16 >> k, "x53");
        end

        // Backpressure with a competing in_valid during SUB and HOLD.
        inValid[2]  = 1'b1;
        stateIn[2]  = B_IN;
        outReady[2] = 1'b0;
        @(negedge clk);
        stateIn[2] = ZEROS;
        waitOut(2, lat);
        check("bp latency", 128'(lat), 128'(4));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold data", stateOut[2], B_OUT);
            check("bp hold valid", 128'(outValid[2]), 128'(1));
            check("bp hold in_ready", 128'(inReady[2]), 128'(0));
        end
        $display("L4 backpressure: held %h for 10 cycles", stateOut[2]);
        inValid[2]  = 1'b0;
        outReady[2] = 1'b1;
        @(negedge clk);
        check("bp release valid", 128'(outValid[2]), 128'(0));
        check("bp release in_ready", 128'(inReady[2]), 128'(1));
        check("bp release data", stateOut[2], ZEROS);
        @(negedge clk);
        check("bp no stray accept", 128'(inReady[2]), 128'(1));

        // Back-to-back: in_valid held across two blocks.
        nAcc = 0; nOut = 0; pend = 1'b0;
        accCyc[0] = 0; accCyc[1] = 0;
        outs[0] = '0; outs[1] = '0;
        inValid[2]  = 1'b1;
        stateIn[2]  = B_IN;
        outReady[2] = 1'b1;
        for (int cyc = 0; cyc < 40 && nOut < 2; cyc++) begin
            if (pend) begin
                if (nAcc == 1) stateIn[2] = ONES;
                else           inValid[2] = 1'b0;
                pend = 1'b0;
            end
            if (outValid[2] === 1'b1) begin
                outs[nOut] = stateOut[2];
                nOut++;
            end
            if (inReady[2] === 1'b1 && inValid[2] === 1'b1 && nAcc < 2) begin
                accCyc[nAcc] = cyc;
                nAcc++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        inValid[2] = 1'b0;
        $display("L4 back-to-back: accepts at %0d and %0d, outs %h %h",
                 accCyc[0], accCyc[1], outs[0], outs[1]);
        check("b2b accepts", 128'(nAcc), 128'(2));
        check("b2b spacing", 128'(accCyc[1] - accCyc[0]), 128'(6));
        check("b2b out0", outs[0], B_OUT);
        check("b2b out1", outs[1], S16);
        @(negedge clk);

        // Asynchronous reset during the second SUB cycle.
        inValid[2] = 1'b1;
        stateIn[2] = B_IN;
        @(negedge clk);
        inValid[2] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("L4 mid-run reset: in_ready %b out_valid %b", inReady[2], outValid[2]);
        check("rst in_ready", 128'(inReady[2]), 128'(1));
        check("rst out_valid", 128'(outValid[2]), 128'(0));
        check("rst state_out", stateOut[2], ZEROS);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (outValid[2] !== 1'b0) seen++;
        end
        check("rst no aborted output", 128'(seen), 128'(0));
        runBlock(2, B_IN, B_OUT, 4, "post-reset");

        // Chained into shift_rows.
        inValid[2] = 1'b1;
        stateIn[2] = B_IN;
        @(negedge clk);
        inValid[2] = 1'b0;
        waitOut(2, lat);
        $display("L4 shift_rows chain: %h", shiftRows(stateOut[2]));
        check("chain shift_rows", shiftRows(stateOut[2]), SR_OUT);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative AES SubBytes stage for the encryption datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes it through LANES shared S-box lookups per cycle. It presents the substituted state, which feeds shift_rows directly. It trades latency for area compared with a 16-S-box combinational SubBytes.

## Interface
- LANES, default 4: S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16; N = 16/LANES chunk cycles.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  state_in holds a block to process.
- in_ready  output  1  block can accept a new state.
- state_in  input  [0:127]  input state; byte b at bits [8b:8b+7], column-major (bytes 0–3 = column 0).
- out_valid  output  1  state_out holds the substituted block.
- out_ready  input  1  consumer accepts state_out.
- state_out  output  [0:127]  substituted state; same byte ordering as state_in, as shift_rows expects.

## Operation
- Registers:
  - 128-bit buffer `buf`.
  - Chunk counter `cnt`, width clog2(N) bits, minimum 1.
  - FSM with states IDLE, SUB, HOLD.
- S-box is the FIPS-197 forward S-box, implemented as a combinational 256-entry function. The same function is instantiated LANES times.
- IDLE:
  - in_ready = 1.
  - On in_valid: buf <= state_in, cnt <= 0, go to SUB.
- SUB:
  - Each cycle, bytes cnt·LANES … cnt·LANES+LANES−1 of buf are replaced in place by their S-box images. All other bytes hold.
  - cnt increments each cycle.
  - On the cycle processing chunk N−1: cnt <= 0, go to HOLD.
- HOLD:
  - out_valid = 1, state_out = buf.
  - On out_ready: go to IDLE.
- in_ready = 1 only in IDLE. out_valid = 1 only in HOLD.
- There is no overlap between output drain and new input. A new block can be accepted no earlier than the cycle after the HOLD→IDLE edge.
- state_out = all zeros whenever out_valid = 0. buf contents are never visible mid-substitution.
- in_valid or state_in activity outside IDLE is ignored. state_in is sampled only at the acceptance edge.
- out_ready outside HOLD is ignored.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - FSM = IDLE, buf = 0, cnt = 0.
  - in_ready = 1, out_valid = 0, state_out = 0.
- Reset applies regardless of current state. A block in SUB or HOLD is discarded with no out_valid pulse.
- Deassertion is synchronous to clk, per codebase reset practice.
- Latency: acceptance edge E0. Chunk substitutions happen on edges E1…EN. out_valid is high in the cycle after EN, i.e. N cycles after E0.
  - LANES = 4: out_valid high 4 cycles after acceptance.
  - LANES = 16: out_valid high 1 cycle after acceptance.
- HOLD is held indefinitely while out_ready = 0. state_out stays stable and equal to the final buf.
- Throughput: one block per N+2 cycles with out_ready tied high (accept, N SUB cycles, 1 HOLD cycle).
- Byte order is processed ascending: byte 0 is substituted first, byte 15 last.
- All outputs are driven from registers or from FSM-state decode. There is no combinational path from in_valid or out_ready to in_ready or out_valid.

## Test plan
- FIPS-197 Appendix B round-1 vector, LANES=4, out_ready=1:
  - state_in = 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: state_out = d42711aee0bf98f1b8b45de51e415230, out_valid exactly 4 cycles after acceptance for 1 cycle, then in_ready = 1.
- Boundary bytes:
  - All 0x00 input → all 0x63.
  - All 0xff → all 0x16.
  - 0x53 repeated → all 0xed.
  - Repeat for LANES = 1, 2, 8, 16, checking latency = 16, 8, 2, 1 cycles.
- Backpressure:
  - out_ready held 0 for 10 cycles in HOLD: state_out and out_valid stable, in_ready = 0.
  - in_valid pulsed with a different state during SUB and HOLD: ignored, output unchanged.
  - out_ready=1: IDLE next cycle.
- Back-to-back: in_valid held high with two blocks, out_ready=1.
  - Second block is accepted the cycle after HOLD exits.
  - Both outputs are correct.
  - Spacing is N+2 cycles.
- Reset mid-operation: assert rst asynchronously during cycle 2 of SUB.
  - Required: in_ready=1, out_valid=0, state_out=0 immediately, with no output for the aborted block.
  - A subsequent block processes correctly.
- Chained check with shift_rows fed from state_out, Appendix B vector:
  - Required: shift_rows output = d4bf5d30e0b452aeb84111f11e2798e5.
